uart_tx_fifo_engine: RTL

UART0 transmit datapath that sits directly downstream of the peripheral AXI4 register file in soc_peripherals_top. Bytes written to the UART0 TX data register (offset 0x0C) are pushed into a small FIFO. The FIFO is drained by a baud-rate serializer that drives UART0_tx_o with 8N1 frames, or 8N2 frames when two stop bits are selected. Status outputs feed the register file's UART status word.

---
 rtl/uart_tx_fifo_engine.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo_engine.sv
// rtl/uart_tx_fifo_engine.sv - UART transmit FIFO with 8N1/8N2 baud-rate serializer
module uart_tx_fifo_engine #(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [DIV_WIDTH-1:0]          baud_div_i,
    input  logic                          stop2_i,
    input  logic                          wr_valid_i,
    input  logic [7:0]                    wr_data_i,
    output logic                          wr_ready_o,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          fifo_empty_o,
    output logic                          fifo_full_o,
    output logic                          tx_done_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]           mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;

    state_t               state;
    logic [DIV_WIDTH-1:0] baud_cnt;
    logic [DIV_WIDTH-1:0] div_q;
    logic                 stop2_q;
    logic                 stop_second;
    logic [2:0]           bit_idx;
    logic [7:0]           shreg;
    logic                 tx_q;
    logic                 done_q;

    logic push;
    logic pop;
    logic bit_end;
    logic frame_end;

    assign fifo_count_o = count;
    assign fifo_empty_o = (count == '0);
    assign fifo_full_o  = (count == (AW+1)'(FIFO_DEPTH));
    assign wr_ready_o   = !fifo_full_o;
    assign busy_o       = (state != IDLE) || !fifo_empty_o;
    assign tx_o         = tx_q;
    assign tx_done_o    = done_q;

    assign push      = wr_valid_i && !fifo_full_o;
    assign bit_end   = (baud_cnt == div_q);
    assign frame_end = (state == STOP) && bit_end && (!stop2_q || stop_second);
    // Popping at the end of a stop period chains frames with no idle gap.
    assign pop       = !fifo_empty_o && ((state == IDLE) || frame_end);

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            div_q       <= '0;
            stop2_q     <= 1'b0;
            stop_second <= 1'b0;
            bit_idx     <= '0;
            shreg       <= '0;
            tx_q        <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (pop) begin
                // Frame parameters are frozen here for the whole frame.
                state       <= START;
                shreg       <= mem[rd_ptr];
                div_q       <= baud_div_i;
                stop2_q     <= stop2_i;
                stop_second <= 1'b0;
                bit_idx     <= '0;
                baud_cnt    <= '0;
                tx_q        <= 1'b0;
                done_q      <= frame_end;
            end else begin
                case (state)
                    IDLE: begin
                        tx_q <= 1'b1;
                    end
                    START: begin
                        if (bit_end) begin
                            state    <= DATA;
                            baud_cnt <= '0;
                            tx_q     <= shreg[0];
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            baud_cnt <= '0;
                            if (bit_idx == 3'd7) begin
                                state <= STOP;
                                tx_q  <= 1'b1;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                                shreg   <= {1'b0, shreg[7:1]};
                                tx_q    <= shreg[1];
                            end
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (bit_end) begin
                            baud_cnt <= '0;
                            if (stop2_q && !stop_second) begin
                                stop_second <= 1'b1;
                            end else begin
                                state  <= IDLE;
                                done_q <= 1'b1;
                            end
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        tx_q  <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
